// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit; the decoder builds
// the EX control field from the same op constants.
package ex_muldiv_pkg;

    localparam int unsigned MULDIV_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_e;

    // Per-operation control latched at start
    typedef struct packed {
        logic is_div;
        logic neg_q;   // negate product (mul) or quotient (div)
        logic neg_r;   // negate remainder (div)
    } muldiv_ctrl_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle on
// unsigned magnitudes, signs restored in a final fix-up cycle.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    input  logic             flush_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    muldiv_state_e    state_q, state_d;
    muldiv_ctrl_t     ctrl_q, ctrl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Operand conditioning at start: magnitudes plus result signs
    logic             is_div, is_signed, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_div    = op_is_div(op_i);
    assign is_signed = op_is_signed(op_i);
    assign a_neg     = is_signed & rs_i[WIDTH-1];
    assign b_neg     = is_signed & rt_i[WIDTH-1];
    assign b_zero    = (rt_i == '0);
    assign a_mag     = a_neg ? -rs_i : rs_i;
    assign b_mag     = b_neg ? -rt_i : rt_i;

    // Shift-add multiply step: acc_hi accumulates, acc_lo holds the multiplier
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi_q} + {1'b0, {WIDTH{acc_lo_q[0]}} & opb_q};

    // Restoring divide step: acc_hi is the partial remainder, acc_lo the dividend/quotient
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_qbit;
    logic [WIDTH-1:0] div_rem;

    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_qbit  = ~div_diff[WIDTH];
    assign div_rem   = div_qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

    // Sign fix-up of the finished magnitudes
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = ctrl_q.neg_q ? -prod : prod;
    assign quo_fix  = ctrl_q.neg_q ? -acc_lo_q : acc_lo_q;
    assign rem_fix  = ctrl_q.neg_r ? -acc_hi_q : acc_hi_q;

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mthi_i) hi_d = rs_i;
                if (mtlo_i) lo_d = rs_i;
                if (start_i && !flush_i) begin
                    state_d       = ST_CALC;
                    cnt_d         = '0;
                    ctrl_d.is_div = is_div;
                    // Divide by zero keeps an all-ones quotient unsigned
                    ctrl_d.neg_q  = (a_neg ^ b_neg) & ~(is_div & b_zero);
                    ctrl_d.neg_r  = a_neg;
                    acc_hi_d      = '0;
                    acc_lo_d      = is_div ? a_mag : b_mag;
                    opb_d         = is_div ? b_mag : a_mag;
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    if (ctrl_q.is_div) begin
                        acc_hi_d = div_rem;
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_qbit};
                    end else begin
                        acc_hi_d = mul_sum[WIDTH:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!flush_i) begin
                    if (ctrl_q.is_div) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: transaction-level HI/LO model checked every cycle,
// plus directed vectors with literal results and latency checks.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int NV = 10;

    logic        clk_i   = 1'b0;
    logic        rst_n_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i    = 2'b00;
    logic [31:0] rs_i    = '0;
    logic [31:0] rt_i    = '0;
    logic        flush_i = 1'b0;
    logic        mthi_i  = 1'b0;
    logic        mtlo_i  = 1'b0;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int n_tests = 0;
    int n_fail  = 0;

    ex_muldiv #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .start_i (start_i),
        .op_i    (op_i),
        .rs_i    (rs_i),
        .rt_i    (rt_i),
        .flush_i (flush_i),
        .mthi_i  (mthi_i),
        .mtlo_i  (mtlo_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    // Architectural result of one operation, returned as {HI, LO}
    function automatic logic [63:0] model_op(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        p  = '0;
        case (op)
            OP_MULT:  p = 64'(longint'(sa) * longint'(sb));
            OP_MULTU: p = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0)
                    p = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    p = {32'd0, 32'h8000_0000};
                else
                    p = {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else            p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // Transaction model: an accepted op occupies WIDTH+1 edges, then HI/LO update
    int unsigned m_left = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [63:0] m_res  = '0;
    logic        m_done = 1'b0;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (mthi_i) m_hi <= rs_i;
                if (mtlo_i) m_lo <= rs_i;
                if (start_i && !flush_i) begin
                    m_left <= WIDTH + 1;
                    m_res  <= model_op(op_i, rs_i, rt_i);
                end
            end else if (flush_i) begin
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                    m_done <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one op from IDLE; returns at the negedge where done_o is seen
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic mt_lo, output int lat, output int bcyc);
        start_i = 1'b1;
        mtlo_i  = mt_lo;
        op_i    = op;
        rs_i    = a;
        rt_i    = b;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        mtlo_i  = 1'b0;
        if (mt_lo) chk("mtlo_with_start", lo_o, a);
        lat  = 0;
        bcyc = 0;
        while (!done_o && lat < 100) begin
            if (busy_o) bcyc++;
            @(negedge clk_i);
            lat++;
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [NV];

    initial begin
        int lat, bcyc, pulses;
        vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{OP_DIV,   32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        vecs[6] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
        vecs[9] = '{OP_MULT,  32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};

        #2 rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;

        // Per-cycle comparison of every output against the model
        fork
            forever begin
                @(negedge clk_i);
                chk("mon_busy", 32'(busy_o), 32'(m_left != 0));
                chk("mon_done", 32'(done_o), 32'(m_done));
                chk("mon_hi", hi_o, m_hi);
                chk("mon_lo", lo_o, m_lo);
            end
        join_none

        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);

        // Directed vectors, each started in the done cycle of the previous one
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, bcyc);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd33);
            chk($sformatf("v%0d_busy_cycles", i), 32'(bcyc), 32'd33);
            chk($sformatf("v%0d_hi", i), hi_o, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), lo_o, vecs[i].lo);
            chk($sformatf("v%0d_model_hi", i), m_hi, vecs[i].hi);
            chk($sformatf("v%0d_model_lo", i), m_lo, vecs[i].lo);
        end

        // MTHI, then a flushed DIVU with a start attempt while busy
        mthi_i = 1'b1;
        rs_i   = 32'h0000_1234;
        @(negedge clk_i);
        mthi_i = 1'b0;
        chk("mthi_value", hi_o, 32'h0000_1234);
        start_i = 1'b1;
        op_i    = OP_DIVU;
        rs_i    = 32'd100;
        rt_i    = 32'd7;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_i);
            if (c == 3) begin
                start_i = 1'b1;
                op_i    = OP_MULTU;
                rs_i    = 32'd5;
                rt_i    = 32'd5;
            end
            if (c == 4) start_i = 1'b0;
        end
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("flush_busy", 32'(busy_o), 32'd0);
        chk("flush_done", 32'(done_o), 32'd0);
        chk("flush_hi", hi_o, 32'h0000_1234);
        chk("flush_lo", lo_o, vecs[NV-1].lo);
        pulses = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (done_o) pulses++;
        end
        chk("flush_no_done", 32'(pulses), 32'd0);
        chk("flush_lo_kept", lo_o, vecs[NV-1].lo);

        // Asynchronous reset in CALC cycle 5
        start_i = 1'b1;
        op_i    = OP_MULTU;
        rs_i    = 32'h0000_ABCD;
        rt_i    = 32'h0000_1234;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        chk("midrst_hi", hi_o, 32'd0);
        chk("midrst_lo", lo_o, 32'd0);
        @(negedge clk_i);
        #2 rst_n_i = 1'b1;
        @(negedge clk_i);
        run_op(OP_MULTU, 32'd6, 32'd7, 1'b0, lat, bcyc);
        chk("postrst_latency", 32'(lat), 32'd33);
        chk("postrst_lo", lo_o, 32'd42);
        chk("postrst_hi", hi_o, 32'd0);

        // MTLO in the start cycle is visible, then overwritten by the product
        @(negedge clk_i);
        run_op(OP_MULTU, 32'd3, 32'd3, 1'b1, lat, bcyc);
        chk("mtlo_op_lo", lo_o, 32'd9);

        // Back-to-back: second start in the cycle the first done_o is seen
        @(negedge clk_i);
        run_op(OP_MULTU, 32'd2, 32'd3, 1'b0, lat, bcyc);
        chk("b2b_first_lo", lo_o, 32'd6);
        chk("b2b_first_hi", hi_o, 32'd0);
        run_op(OP_DIVU, 32'd9, 32'd4, 1'b0, lat, bcyc);
        chk("b2b_done_gap", 32'(lat + 1), 32'd34);
        chk("b2b_second_lo", lo_o, 32'd2);
        chk("b2b_second_hi", hi_o, 32'd1);

        @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage, consuming the rs/rt operands and the EX control field latched by the ID/EX pipeline register. It executes MULT, MULTU, DIV and DIVU over multiple cycles and owns the architectural HI/LO registers. While an operation is in flight it raises a stall toward the hazard unit. HI/LO values feed the MFHI/MFLO path into EX/MEM.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH.
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  start request; sampled only in IDLE.
- op_i  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_i  in  WIDTH  operand A (multiplicand / dividend).
- rt_i  in  WIDTH  operand B (multiplier / divisor).
- flush_i  in  1  abort in-flight operation; HI/LO untouched.
- mthi_i  in  1  write rs_i to HI (IDLE only).
- mtlo_i  in  1  write rs_i to LO (IDLE only).
- busy_o  out  1  operation in flight; also the stall request.
- done_o  out  1  one-cycle pulse: HI/LO just updated by an operation.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: start_i=1 and flush_i=0 -> latch op, take magnitudes for signed ops (record result signs), clear counter, go to CALC. start_i while not IDLE is ignored; the hazard unit must hold the instruction.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter runs 0..WIDTH-1; after step WIDTH-1 go to FIX.
- FIX: apply sign correction, write HI/LO, assert done register, go to IDLE.
- Multiply: {HI,LO} = 2*WIDTH-bit product; signed ops correct via two's-complement negation of the full product.
- Divide: LO = quotient, HI = remainder; quotient sign = sign(A) xor sign(B); remainder takes sign of A (truncating division).
- Divide by zero: LO = all ones, HI = A (unsigned and signed alike); no exception.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
- flush_i in CALC or FIX: return to IDLE next edge, no HI/LO write, no done_o. flush_i and start_i together in IDLE: flush wins, nothing starts.
- mthi_i/mtlo_i honoured only in IDLE; ignored otherwise. Same cycle as accepted start: the write happens; the operation result later overwrites it.

## Timing
- Reset: state IDLE, busy_o=0, done_o=0, hi_o=0, lo_o=0, counter=0; reset mid-operation discards all work.
- Start accepted at edge E0. busy_o high from after E0 until edge E0+WIDTH+1 (WIDTH CALC cycles + 1 FIX cycle).
- New HI/LO visible after edge E0+WIDTH+1; done_o high exactly that cycle; busy_o low that cycle.
- Next start accepted earliest at edge E0+WIDTH+2 (back-to-back period WIDTH+2 edges).
- busy_o, done_o, hi_o, lo_o are registered outputs, no combinational paths from inputs.
- mthi/mtlo: new value visible the cycle after the edge.

## Structure
- Shared package ex_muldiv_pkg: op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and state encoding; the decoder uses the same op constants when building the EX control field.
- Datapath kept in one module; a sub-module is not required. If split, the single-step divider is muldiv_div_step (remainder, quotient bit in; updated remainder, quotient bit out).

## Test plan
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, done_o exactly 33 edges after start, busy_o high 33 cycles.
- MULT -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=0x00000007; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x1234 then DIVU 100 / 7 started; flush_i at CALC cycle 10 -> HI=0x1234 and LO unchanged, busy_o low next cycle, no done_o; start during busy ignored.
- rst_n_i asserted at CALC cycle 5 -> all outputs 0 immediately; after release, MULTU 6 x 7 -> LO=42, HI=0.
- Back-to-back: MULTU 2x3 then DIVU 9/4 started the cycle done_o is seen -> LO=6 then LO=2, HI=1, second done_o 34 edges after first.
